fluxo_dados_gen: RTL and testbench

Parametrised datapath for the button-sequence memory game. It generalises button count and memory depth, and replaces the fixed ROM with a write-first synchronous RAM so rounds can record new plays. It adds a one-hot validity check on captured plays and a timeout that can be gated and is restarted on each play. It sits between the game control unit (which drives every `zera*`/`conta*`/`registra*`/`escreve*` strobe) and the board I/O.

---
 rtl/fluxo_dados_gen.sv | 145 ++++++++++++++
 tb/tb_fluxo_dados_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_gen.sv
// fluxo_dados_gen: memory-game datapath with counters, a write-first RAM, a play register and timeout/display timers.
// Latency: RAM read, play register and flags settle one clock after their strobe; no backpressure, strobes act every cycle.
module fluxo_dados_gen #(
  parameter int N              = 4,
  parameter int A              = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TMR_CYCLES     = 500
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] botoes,
  input  logic         zeraE,
  input  logic         contaE,
  input  logic         zeraS,
  input  logic         contaS,
  input  logic         zeraR,
  input  logic         registraR,
  input  logic         escreveM,
  input  logic         habTO,
  input  logic         zeraTMR,
  input  logic         contaTMR,
  output logic         jogada_feita,
  output logic         jogada_valida,
  output logic         chavesIgualMemoria,
  output logic         enderecoIgualSequencia,
  output logic         enderecoMenorQueSequencia,
  output logic         fimE,
  output logic         fimS,
  output logic         timeout,
  output logic         fimTMR,
  output logic         db_tem_jogada,
  output logic [A-1:0] db_contagem,
  output logic [A-1:0] db_sequencia,
  output logic [N-1:0] db_jogada,
  output logic [N-1:0] db_memoria
);

  localparam int DEPTH = 2 ** A;
  localparam int TOW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMW   = (TMR_CYCLES > 1) ? $clog2(TMR_CYCLES) : 1;

  logic [A-1:0]   end_q, end_d;
  logic [A-1:0]   seq_q, seq_d;
  logic [N-1:0]   jog_q, jog_d;
  logic           val_q, val_d;
  logic [N-1:0]   rd_q, rd_d;
  logic           tem_q;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           to_q, to_d;
  logic [TMW-1:0] tmr_q, tmr_d;
  logic [N-1:0]   mem [DEPTH];

  logic tem;
  logic one_hot;
  logic to_clr;
  logic to_inc;

  assign tem     = |botoes;
  assign one_hot = (botoes != '0) && ((botoes & (botoes - N'(1))) == '0);
  assign to_clr  = zeraE | contaE | jogada_feita;
  assign to_inc  = habTO & ~tem & ~to_q;

  always_comb begin
    end_d    = end_q;
    seq_d    = seq_q;
    jog_d    = jog_q;
    val_d    = val_q;
    to_cnt_d = to_cnt_q;
    to_d     = to_q;
    tmr_d    = tmr_q;

    if (zeraE)       end_d = '0;
    else if (contaE) end_d = end_q + A'(1);

    if (zeraS)       seq_d = '0;
    else if (contaS) seq_d = seq_q + A'(1);

    if (zeraR) begin
      jog_d = '0;
      val_d = 1'b0;
    end else if (registraR) begin
      jog_d = botoes;
      val_d = one_hot;
    end

    // Count saturates at TIMEOUT_CYCLES-1; the following idle edge raises the sticky flag.
    if (to_clr) begin
      to_cnt_d = '0;
      to_d     = 1'b0;
    end else if (to_inc) begin
      if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) to_d = 1'b1;
      else                                       to_cnt_d = to_cnt_q + TOW'(1);
    end

    if (zeraTMR)        tmr_d = '0;
    else if (contaTMR)  tmr_d = (tmr_q == TMW'(TMR_CYCLES - 1)) ? '0 : tmr_q + TMW'(1);
  end

  // Write and read share the address, so write-first reduces to forwarding the play register.
  assign rd_d = escreveM ? jog_q : mem[end_q];

  always_ff @(posedge clock) begin
    if (escreveM) mem[end_q] <= jog_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      end_q    <= '0;
      seq_q    <= '0;
      jog_q    <= '0;
      val_q    <= 1'b0;
      rd_q     <= '0;
      tem_q    <= 1'b1;
      to_cnt_q <= '0;
      to_q     <= 1'b0;
      tmr_q    <= '0;
    end else begin
      end_q    <= end_d;
      seq_q    <= seq_d;
      jog_q    <= jog_d;
      val_q    <= val_d;
      rd_q     <= rd_d;
      tem_q    <= tem;
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
      tmr_q    <= tmr_d;
    end
  end

  assign jogada_feita              = tem & ~tem_q;
  assign jogada_valida             = val_q;
  assign chavesIgualMemoria        = val_q && (jog_q == rd_q);
  assign enderecoIgualSequencia    = (end_q == seq_q);
  assign enderecoMenorQueSequencia = (end_q < seq_q);
  assign fimE                      = &end_q;
  assign fimS                      = &seq_q;
  assign timeout                   = to_q;
  assign fimTMR                    = (tmr_q == TMW'(TMR_CYCLES - 1));
  assign db_tem_jogada             = tem;
  assign db_contagem               = end_q;
  assign db_sequencia              = seq_q;
  assign db_jogada                 = jog_q;
  assign db_memoria                = rd_q;

endmodule

// File: tb/tb_fluxo_dados_gen.sv
// Bench for fluxo_dados_gen: directed table, hand sequences for timeout/timer, and random stimulus against a reference model.
module tb_fluxo_dados_gen;
  localparam int N   = 4;
  localparam int A   = 3;
  localparam int TO  = 8;
  localparam int TMR = 4;

  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] ZE = 7'b1000000;
  localparam logic [6:0] CE = 7'b0100000;
  localparam logic [6:0] ZS = 7'b0010000;
  localparam logic [6:0] CS = 7'b0001000;
  localparam logic [6:0] ZR = 7'b0000100;
  localparam logic [6:0] RR = 7'b0000010;
  localparam logic [6:0] WM = 7'b0000001;

  logic         clock, reset;
  logic [N-1:0] botoes;
  logic         zeraE, contaE, zeraS, contaS, zeraR, registraR, escreveM;
  logic         habTO, zeraTMR, contaTMR;
  logic         jogada_feita, jogada_valida, chavesIgualMemoria;
  logic         enderecoIgualSequencia, enderecoMenorQueSequencia;
  logic         fimE, fimS, timeout, fimTMR, db_tem_jogada;
  logic [A-1:0] db_contagem, db_sequencia;
  logic [N-1:0] db_jogada, db_memoria;

  fluxo_dados_gen #(.N(N), .A(A), .TIMEOUT_CYCLES(TO), .TMR_CYCLES(TMR)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
    .habTO(habTO), .zeraTMR(zeraTMR), .contaTMR(contaTMR),
    .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
    .chavesIgualMemoria(chavesIgualMemoria),
    .enderecoIgualSequencia(enderecoIgualSequencia),
    .enderecoMenorQueSequencia(enderecoMenorQueSequencia),
    .fimE(fimE), .fimS(fimS), .timeout(timeout), .fimTMR(fimTMR),
    .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem),
    .db_sequencia(db_sequencia), .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain integers; a memory word of -1 means never written.
  int m_addr, m_seq, m_jog, m_val, m_rd, m_idle, m_tmr, m_temp;
  int m_mem [8];

  function automatic void model_reset();
    m_addr = 0; m_seq = 0; m_jog = 0; m_val = 0; m_rd = 0;
    m_idle = 0; m_tmr = 0; m_temp = 1;
  endfunction

  function automatic void model_step();
    int tem;
    int jf;
    tem = (botoes != 0) ? 1 : 0;
    jf  = (tem == 1 && m_temp == 0) ? 1 : 0;
    if (escreveM) begin
      m_rd = m_jog;
      m_mem[m_addr] = m_jog;
    end else begin
      m_rd = m_mem[m_addr];
    end
    if (zeraR) begin
      m_jog = 0; m_val = 0;
    end else if (registraR) begin
      m_jog = int'(botoes);
      m_val = ($countones(botoes) == 1) ? 1 : 0;
    end
    if (zeraE)       m_addr = 0;
    else if (contaE) m_addr = (m_addr + 1) % 8;
    if (zeraS)       m_seq = 0;
    else if (contaS) m_seq = (m_seq + 1) % 8;
    if (zeraE || contaE || jf == 1)             m_idle = 0;
    else if (habTO && tem == 0 && m_idle < TO)  m_idle = m_idle + 1;
    if (zeraTMR)       m_tmr = 0;
    else if (contaTMR) m_tmr = (m_tmr + 1) % TMR;
    m_temp = tem;
  endfunction

  function automatic logic [23:0] model_vec();
    logic tem, ch;
    logic [2:0] a3, s3;
    logic [3:0] j4, r4;
    tem = (botoes != 0);
    a3 = m_addr[2:0]; s3 = m_seq[2:0]; j4 = m_jog[3:0]; r4 = m_rd[3:0];
    ch = (m_val != 0) && (m_jog == m_rd);
    return {tem && (m_temp == 0), m_val != 0, ch, m_addr == m_seq, m_addr < m_seq,
            m_addr == 7, m_seq == 7, m_idle >= TO, m_tmr == TMR - 1, tem, a3, s3, j4, r4};
  endfunction

  function automatic logic [23:0] model_mask();
    return (m_rd < 0) ? 24'hDFFFF0 : 24'hFFFFFF;
  endfunction

  function automatic logic [23:0] dut_vec();
    return {jogada_feita, jogada_valida, chavesIgualMemoria, enderecoIgualSequencia,
            enderecoMenorQueSequencia, fimE, fimS, timeout, fimTMR, db_tem_jogada,
            db_contagem, db_sequencia, db_jogada, db_memoria};
  endfunction

  task automatic set_strobes(input logic [6:0] st);
    {zeraE, contaE, zeraS, contaS, zeraR, registraR, escreveM} = st;
  endtask

  task automatic clk_edge();
    @(posedge clock);
    model_step();
    @(negedge clock);
    #1;
  endtask

  task automatic run_random(input int n);
    logic [23:0] msk;
    for (int cyc = 0; cyc < n; cyc++) begin
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0: botoes = '0;
          1: botoes = 4'b0001 << $urandom_range(3);
          2: botoes = 4'($urandom_range(15));
          default: botoes = '0;
        endcase
      end
      zeraE     = ($urandom_range(31) == 0);
      contaE    = ($urandom_range(15) == 0);
      zeraS     = ($urandom_range(15) == 0);
      contaS    = ($urandom_range(7) == 0);
      zeraR     = ($urandom_range(15) == 0);
      registraR = ($urandom_range(5) == 0);
      escreveM  = ($urandom_range(5) == 0);
      habTO     = ($urandom_range(3) != 0);
      zeraTMR   = ($urandom_range(15) == 0);
      contaTMR  = ($urandom_range(3) != 0);
      #1;
      msk = model_mask();
      check($sformatf("rand%0d", cyc), dut_vec() & msk, model_vec() & msk);
      clk_edge();
    end
  endtask

  typedef struct {
    logic [3:0] b;
    logic [6:0] st;
    logic [2:0] c;
    logic [2:0] s;
    logic [3:0] j;
    logic [3:0] m;
    logic       chk;
    logic [5:0] f;  // {chaves, valida, fimE, fimS, menor, igual}
  } row_t;

  function automatic row_t mk(input logic [3:0] b, input logic [6:0] st, input logic [2:0] c,
                              input logic [2:0] s, input logic [3:0] j, input logic [3:0] m,
                              input logic chk, input logic [5:0] f);
    row_t r;
    r.b = b; r.st = st; r.c = c; r.s = s; r.j = j; r.m = m; r.chk = chk; r.f = f;
    return r;
  endfunction

  row_t tbl [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Write/read-back, invalid play, simultaneous strobes, counter wrap and compare.
    tbl.push_back(mk(4'h1, RR,      0, 0, 4'h1, 4'h0, 0, 6'b010001));
    tbl.push_back(mk(4'h0, WM,      0, 0, 4'h1, 4'h1, 1, 6'b110001));
    tbl.push_back(mk(4'h0, CE,      1, 0, 4'h1, 4'h1, 1, 6'b110000));
    tbl.push_back(mk(4'h4, RR,      1, 0, 4'h4, 4'h0, 0, 6'b010000));
    tbl.push_back(mk(4'h0, WM,      1, 0, 4'h4, 4'h4, 1, 6'b110000));
    tbl.push_back(mk(4'h0, CE,      2, 0, 4'h4, 4'h4, 1, 6'b110000));
    tbl.push_back(mk(4'h8, RR,      2, 0, 4'h8, 4'h0, 0, 6'b010000));
    tbl.push_back(mk(4'h0, WM,      2, 0, 4'h8, 4'h8, 1, 6'b110000));
    tbl.push_back(mk(4'h0, CE,      3, 0, 4'h8, 4'h8, 1, 6'b110000));
    tbl.push_back(mk(4'h1, ZE | RR, 0, 0, 4'h1, 4'h0, 0, 6'b010001));
    tbl.push_back(mk(4'h0, NO,      0, 0, 4'h1, 4'h1, 1, 6'b110001));
    tbl.push_back(mk(4'h0, CE,      1, 0, 4'h1, 4'h1, 1, 6'b110000));
    tbl.push_back(mk(4'h0, NO,      1, 0, 4'h1, 4'h4, 1, 6'b010000));
    tbl.push_back(mk(4'h5, RR,      1, 0, 4'h5, 4'h4, 1, 6'b000000));
    tbl.push_back(mk(4'h0, WM,      1, 0, 4'h5, 4'h5, 1, 6'b000000));
    tbl.push_back(mk(4'h5, RR,      1, 0, 4'h5, 4'h5, 1, 6'b000000));
    tbl.push_back(mk(4'h2, RR | WM, 1, 0, 4'h2, 4'h5, 1, 6'b010000));
    tbl.push_back(mk(4'h0, NO,      1, 0, 4'h2, 4'h5, 1, 6'b010000));
    tbl.push_back(mk(4'h0, WM | CE, 2, 0, 4'h2, 4'h2, 1, 6'b110000));
    tbl.push_back(mk(4'h0, ZE,      0, 0, 4'h2, 4'h8, 1, 6'b010001));
    tbl.push_back(mk(4'h0, CE,      1, 0, 4'h2, 4'h1, 1, 6'b010000));
    tbl.push_back(mk(4'h0, NO,      1, 0, 4'h2, 4'h2, 1, 6'b110000));
    tbl.push_back(mk(4'h4, ZR | RR, 1, 0, 4'h0, 4'h2, 1, 6'b000000));
    tbl.push_back(mk(4'h0, ZE | ZS, 0, 0, 4'h0, 4'h0, 0, 6'b000001));
    tbl.push_back(mk(4'h0, CS,      0, 1, 4'h0, 4'h0, 0, 6'b000010));
    tbl.push_back(mk(4'h0, CS,      0, 2, 4'h0, 4'h0, 0, 6'b000010));
    tbl.push_back(mk(4'h0, CS,      0, 3, 4'h0, 4'h0, 0, 6'b000010));
    tbl.push_back(mk(4'h0, CE,      1, 3, 4'h0, 4'h0, 0, 6'b000010));
    tbl.push_back(mk(4'h0, CE,      2, 3, 4'h0, 4'h0, 0, 6'b000010));
    tbl.push_back(mk(4'h0, CE,      3, 3, 4'h0, 4'h0, 0, 6'b000001));
    tbl.push_back(mk(4'h0, CE,      4, 3, 4'h0, 4'h0, 0, 6'b000000));
    tbl.push_back(mk(4'h0, CE,      5, 3, 4'h0, 4'h0, 0, 6'b000000));
    tbl.push_back(mk(4'h0, CE,      6, 3, 4'h0, 4'h0, 0, 6'b000000));
    tbl.push_back(mk(4'h0, CE,      7, 3, 4'h0, 4'h0, 0, 6'b001000));
    tbl.push_back(mk(4'h0, CE,      0, 3, 4'h0, 4'h0, 0, 6'b000010));
    tbl.push_back(mk(4'h0, ZS | CS, 0, 0, 4'h0, 4'h0, 0, 6'b000001));
    tbl.push_back(mk(4'h0, ZE | CE, 0, 0, 4'h0, 4'h0, 0, 6'b000001));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(4'h0, CS, 0, 3'(k), 4'h0, 4'h0, 0, (k == 7) ? 6'b000110 : 6'b000010));
    tbl.push_back(mk(4'h0, CS,      0, 0, 4'h0, 4'h0, 0, 6'b000001));

    for (int i = 0; i < 8; i++) m_mem[i] = -1;
    reset = 1'b0; botoes = 4'b0010; set_strobes(NO);
    habTO = 1'b0; zeraTMR = 1'b0; contaTMR = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("rst_contagem",  32'(db_contagem), 0);
    check("rst_sequencia", 32'(db_sequencia), 0);
    check("rst_igual",     32'(enderecoIgualSequencia), 1);
    check("rst_flags", {fimE, fimS, enderecoMenorQueSequencia, chavesIgualMemoria, timeout, fimTMR, jogada_feita}, 0);
    check("rst_memoria",   32'(db_memoria), 0);

    reset = 1'b1;
    model_reset();
    #1;
    check("held_no_pulse0", 32'(jogada_feita), 0);
    for (int k = 1; k <= 3; k++) begin
      clk_edge();
      check($sformatf("held_no_pulse%0d", k), {jogada_feita, db_tem_jogada, timeout}, 3'b010);
    end
    botoes = '0;
    clk_edge();

    for (int i = 0; i < tbl.size(); i++) begin
      botoes = tbl[i].b;
      set_strobes(tbl[i].st);
      clk_edge();
      check($sformatf("row%0d", i),
            {db_contagem, db_sequencia, db_jogada, jogada_valida, fimE, fimS,
             enderecoMenorQueSequencia, enderecoIgualSequencia},
            {tbl[i].c, tbl[i].s, tbl[i].j, tbl[i].f[4:0]});
      if (tbl[i].chk)
        check($sformatf("row%0d_mem", i), {db_memoria, chavesIgualMemoria}, {tbl[i].m, tbl[i].f[5]});
    end
    set_strobes(NO); botoes = '0;

    // Timeout: rises exactly TO edges after the clear, sticky, cleared by a new press.
    habTO = 1'b1;
    zeraE = 1'b1; clk_edge(); zeraE = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      clk_edge();
      check($sformatf("to_edge%0d", k), 32'(timeout), 32'(k == TO));
    end
    repeat (3) clk_edge();
    check("to_sticky", 32'(timeout), 1);
    botoes = 4'b0001; #1;
    check("jf_pulse", 32'(jogada_feita), 1);
    clk_edge();
    check("to_clr_by_press", {timeout, jogada_feita}, 2'b00);

    // A held button freezes the count; counting resumes from zero on release.
    zeraE = 1'b1; clk_edge(); zeraE = 1'b0;
    repeat (6) clk_edge();
    check("to_frozen", 32'(timeout), 0);
    botoes = '0;
    for (int k = 1; k <= TO; k++) begin
      clk_edge();
      check($sformatf("to_release%0d", k), 32'(timeout), 32'(k == TO));
    end

    habTO = 1'b0;
    zeraE = 1'b1; clk_edge(); zeraE = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      clk_edge();
      check($sformatf("to_disabled%0d", k), 32'(timeout), 0);
    end

    // Display timer: period TMR, restarted by zeraTMR.
    contaTMR = 1'b1; zeraTMR = 1'b1; clk_edge(); zeraTMR = 1'b0;
    check("tmr_start", 32'(fimTMR), 0);
    for (int k = 1; k <= 8; k++) begin
      clk_edge();
      check($sformatf("tmr%0d", k), 32'(fimTMR), 32'((k % TMR) == TMR - 1));
    end
    repeat (2) clk_edge();
    check("tmr_at2", 32'(fimTMR), 0);
    zeraTMR = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      clk_edge();
      zeraTMR = 1'b0;
      check($sformatf("tmr_restart%0d", j), 32'(fimTMR), 32'(j == 4));
    end
    contaTMR = 1'b0;

    run_random(3000);

    // Asynchronous reset between clock edges.
    set_strobes(NO); habTO = 1'b0; zeraTMR = 1'b0; contaTMR = 1'b0;
    reset = 1'b0; #1;
    check("async_rst", {db_contagem, db_sequencia, db_jogada, db_memoria, timeout, jogada_valida, enderecoIgualSequencia}, 17'b1);
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b1;
    model_reset();
    run_random(300);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
